// File: rtl/muldiv_ctrl.sv
// HI/LO owner for the EX stage: runs one mult/div at a time behind a latency countdown.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only with MD_MADD_EN defined.
module muldiv_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [3:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;

   logic        accept;
   logic        is_div;
   logic        div_zero;
   logic        div_ovf;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [63:0] result;
   logic signed [31:0] dvs;
   logic signed [31:0] quo_s;
   logic signed [31:0] rem_s;
   logic [31:0] dvu;
   logic [31:0] quo_u;
   logic [31:0] rem_u;

   always_comb begin
      accept = 1'b0;
      is_div = 1'b0;
      case (op)
         4'd0, 4'd1: accept = 1'b1;
         4'd2, 4'd3: begin
            accept = 1'b1;
            is_div = 1'b1;
         end
`ifdef MD_MADD_EN
         4'd8, 4'd9, 4'd10, 4'd11: accept = 1'b1;
`endif
         default: accept = 1'b0;
      endcase
   end

   // Lower 64 bits of the product of sign-extended operands is the signed product.
   assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   // Divide-by-zero and signed overflow are resolved by the mux below, so the
   // divider only ever sees a safe divisor.
   assign div_zero = (b_q == 32'd0);
   assign div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
   assign dvs      = (div_zero || div_ovf) ? 32'sd1 : $signed(b_q);
   assign quo_s    = $signed(a_q) / dvs;
   assign rem_s    = $signed(a_q) % dvs;
   assign dvu      = div_zero ? 32'd1 : b_q;
   assign quo_u    = a_q / dvu;
   assign rem_u    = a_q % dvu;

   always_comb begin
      result = {hi, lo};
      case (op_q)
         4'd0: result = prod_s;
         4'd1: result = prod_u;
         4'd2: begin
            if (div_zero)
               result = {a_q, 32'hFFFF_FFFF};
            else if (div_ovf)
               result = {32'd0, 32'h8000_0000};
            else
               result = {rem_s, quo_s};
         end
         4'd3: result = div_zero ? {a_q, 32'hFFFF_FFFF} : {rem_u, quo_u};
`ifdef MD_MADD_EN
         4'd8:  result = {hi, lo} + prod_s;
         4'd9:  result = {hi, lo} + prod_u;
         4'd10: result = {hi, lo} - prod_s;
         4'd11: result = {hi, lo} - prod_u;
`endif
         default: result = {hi, lo};
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         busy  <= 1'b0;
         hi    <= 32'd0;
         lo    <= 32'd0;
         op_q  <= 4'd0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (accept) begin
                     op_q  <= op;
                     a_q   <= src_a;
                     b_q   <= src_b;
                     cnt   <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                     busy  <= 1'b1;
                     state <= RUN;
                  end else if (op == 4'd4) begin
                     hi <= src_a;
                  end else if (op == 4'd5) begin
                     lo <= src_a;
                  end
               end
            end
            RUN: begin
               // Any start seen here is dropped; the hazard unit is expected to hold it off.
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  {hi, lo} <= result;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed vector table, hand-written corner sequences, and random ops
// against an arithmetic reference model. MD_MADD_EN selects the accumulate expectations.
module tb_muldiv_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; issues one start pulse, scrambles the live operands
  // afterwards, and counts busy cycles until busy falls (bounded).
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
    op    = 4'($urandom_range(0, 15));
    src_a = $urandom;
    src_b = $urandom;
    cyc   = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) cyc++;
      else if (cyc > 0 || i >= 2) break;
      @(negedge clk);
    end
  endtask

  // Reference model: results derived from the arithmetic definitions directly.
  function automatic void ref_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l, output int cyc);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    cyc = 0;
    case (o)
      4'd0: begin p = 64'(sa * sb); {h, l} = p; cyc = MC; end
      4'd1: begin p = {32'd0, a} * {32'd0, b}; {h, l} = p; cyc = MC; end
      4'd2: begin
        cyc = DC;
        if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = 32'd0; l = 32'h8000_0000; end
        else begin
          q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
          if ((sa < 0) != (sb < 0)) q = -q;
          r = sa - q * sb;
          l = 32'(q);
          h = 32'(r);
        end
      end
      4'd3: begin
        cyc = DC;
        if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin l = a / b; h = a % b; end
      end
      4'd4: h = a;
      4'd5: l = a;
`ifdef MD_MADD_EN
      4'd8:  begin {h, l} = {h, l} + 64'(sa * sb); cyc = MC; end
      4'd9:  begin {h, l} = {h, l} + {32'd0, a} * {32'd0, b}; cyc = MC; end
      4'd10: begin {h, l} = {h, l} - 64'(sa * sb); cyc = MC; end
      4'd11: begin {h, l} = {h, l} - {32'd0, a} * {32'd0, b}; cyc = MC; end
`endif
      default: ;
    endcase
  endfunction

  initial begin
    vec_t        vecs[12];
    int          cyc;
    int          exp_cyc;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [3:0]  ops_list[12];

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 4'd0;
    src_a    = 32'd0;
    src_b    = 32'd0;

    vecs[0]  = '{4'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
    vecs[1]  = '{4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MC};
    vecs[2]  = '{4'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
    vecs[3]  = '{4'd3, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, DC};
    vecs[4]  = '{4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DC};
    vecs[5]  = '{4'd4, 32'hA5A5_A5A5, 32'd0,        32'hA5A5_A5A5, 32'h8000_0000, 0};
    vecs[6]  = '{4'd5, 32'h1234_5678, 32'd0,        32'hA5A5_A5A5, 32'h1234_5678, 0};
    vecs[7]  = '{4'd7, 32'd1,         32'd2,        32'hA5A5_A5A5, 32'h1234_5678, 0};
    vecs[8]  = '{4'd3, 32'd100,       32'd7,        32'd2,         32'd14,        DC};
    vecs[9]  = '{4'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DC};
    vecs[10] = '{4'd2, 32'd0,         32'd0,        32'd0,         32'hFFFF_FFFF, DC};
    vecs[11] = '{4'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MC};

    // reset state
    #2;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // directed table, issued back to back (each start lands on the cycle after busy falls)
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // second start while a DIV is running must be ignored
    start = 1'b1; op = 4'd2; src_a = 32'd100; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) cyc++;
      else break;
      if (i == 2) begin start = 1'b1; op = 4'd0; src_a = 32'd5; src_b = 32'd5; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("run_ignore_cycles", 32'(cyc), 32'(DC));
    check("run_ignore_hi", hi, 32'd1);
    check("run_ignore_lo", lo, 32'd11);

    // accumulate op: active only when the feature is built
    run_op(4'd4, 32'd0, 32'd0, cyc);
    run_op(4'd5, 32'd5, 32'd0, cyc);
    run_op(4'd8, 32'd2, 32'd3, cyc);
`ifdef MD_MADD_EN
    check("madd_cycles", 32'(cyc), 32'(MC));
    check("madd_lo", lo, 32'd11);
`else
    check("madd_cycles", 32'(cyc), 32'd0);
    check("madd_lo", lo, 32'd5);
`endif
    check("madd_hi", hi, 32'd0);

    // async reset in the middle of a DIV discards the pending result
    run_op(4'd4, 32'hDEAD_BEEF, 32'd0, cyc);
    run_op(4'd5, 32'hCAFE_F00D, 32'd0, cyc);
    start = 1'b1; op = 4'd3; src_a = 32'd50; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DC + 2; i++) @(negedge clk);
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_hi", hi, 32'd0);
    check("postrst_lo", lo, 32'd0);

    // randomized ops against the reference model
    ops_list = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd13};
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      o = ops_list[$urandom_range(0, 11)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 15))
        0, 1: b = 32'd0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'($urandom_range(1, 20));
        4: b = 32'(-$urandom_range(1, 20));
        default: ;
      endcase
      ref_op(o, a, b, m_hi, m_lo, exp_cyc);
      run_op(o, a, b, cyc);
      check($sformatf("rnd%0d_op%0d_cycles", i, o), 32'(cyc), 32'(exp_cyc));
      check($sformatf("rnd%0d_op%0d_hi", i, o), hi, m_hi);
      check($sformatf("rnd%0d_op%0d_lo", i, o), lo, m_lo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide controller in the EX stage of the 5-stage pipeline; owns the HI/LO registers.
- Accepts one operation at a time, models multiplier/divider latency with a countdown, and commits results to HI/LO at completion.
- Drives `busy` to the hazard unit, which stalls any HI/LO-using instruction in ID while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family); range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  EX holds a valid HI/LO-writing instruction this cycle
- op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 8 MADD, 9 MADDU, 10 MSUB, 11 MSUBU; others reserved
- src_a  in  32  rs operand (forwarded)
- src_b  in  32  rt operand (forwarded)
- busy  out  1  registered; 1 while a mult/div is in progress
- hi  out  32  HI register contents, for mfhi
- lo  out  32  LO register contents, for mflo

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE, counter=0, busy=0, hi=0, lo=0; any pending result is discarded.
- States: IDLE, RUN.
- IDLE, start=1, op in {0..3, 8..11}:
  - latch operands and op; load counter with N (MULT_CYCLES or DIV_CYCLES); go to RUN; busy=1 from the next cycle.
- IDLE, start=1, op=4 (MTHI) or op=5 (MTLO): hi (or lo) <= src_a at that edge; stays IDLE; busy stays 0.
- start with a reserved op, or with op 8..11 and MD_MADD_EN undefined: ignored, no state change.
- RUN: counter decrements each cycle. At the edge where counter==1:
  - hi/lo <= computed result; state <= IDLE; busy <= 0.
  - Latency: start at cycle T gives busy=1 for cycles T+1..T+N; new hi/lo are visible at T+N+1.
- start while in RUN (any op): ignored. The hazard unit guarantees this never happens; the bench checks that it is ignored.
- Start on the same cycle busy falls: accepted, since state is IDLE at that edge.
- Arithmetic is computed on the latched operands (not on live ports):
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient into lo, remainder into hi.
- Divide by zero (src_b=0): full latency still applies; hi <= src_a, lo <= 32'hFFFF_FFFF (both div and divu).
- DIV overflow (0x8000_0000 / 0xFFFF_FFFF): lo=0x8000_0000, hi=0.
- mfhi/mflo: combinational read of the hi/lo registers. The reader must stall while busy=1.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: ops 8..11 are accepted with MULT_CYCLES latency. At completion, {hi,lo} <= {hi,lo} ± product, 64-bit wrap-around, signed product for 8/10 and unsigned for 9/11. The {hi,lo} value used is the one at completion time.
- Undefined: ops 8..11 are treated as reserved (ignored); no accumulate logic is present.

Test Plan:
- Reset, then start MULT a=0xFFFF_FFFE (-2), b=3 → busy=1 for exactly 5 cycles; then hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=0x0000_0001.
- DIV a=-7 (0xFFFF_FFF9), b=2 → busy for 10 cycles; lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- DIVU a=0x1234, b=0 → lo=0xFFFF_FFFF, hi=0x1234.
- DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- MTHI 0xA5A5_A5A5 → hi updates the next cycle, busy never rises.
- DIV started, second start (MULT) during RUN → ignored; DIV result retained.
- Reset asserted mid-DIV → busy, hi, lo = 0 immediately (async).
- With MD_MADD_EN: hi=0, lo=5, then MADD 2×3 → lo=11.
- Without MD_MADD_EN: MADD 2×3 → busy stays 0, hi/lo unchanged.
